id_imm_sequencer: RTL and testbench

Decode-stage sequencer for the shared immediate sign-extender. Accepts instructions from the IF/ID register over a valid/ready handshake, classifies the opcode, and drives the extender's 2-bit format select. It captures the extended immediate into a registered ID/EX slice with stall and flush support, and keeps a saturating count of illegal opcodes for debug.

---
 rtl/id_imm_sequencer.sv | 165 ++++++++++++++++
 tb/tb_id_imm_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_imm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : id_imm_sequencer
// Description : Decode-stage sequencer for the shared immediate sign-extender.
//               Classifies the opcode of the IF/ID instruction, drives the
//               extender format select, and captures the extended immediate
//               into a single-entry ID/EX register with stall and flush
//               support.  Keeps a saturating count of illegal opcodes.
// Config      : IMM_UTYPE_EN - when defined, LUI/AUIPC decode as U-type with
//               the immediate built internally.  When undefined they are
//               treated as illegal opcodes.
// Ports       : clk, rst_n          clock, asynchronous active-low reset
//               in_valid/in_instr   IF/ID instruction handshake (input side)
//               in_ready            sequencer can accept this cycle
//               imm_sel/imm_in      format select and word to the extender
//               imm_ext             extender result (combinational)
//               flush               squash held and incoming instruction
//               out_valid/out_ready ID/EX handshake (output side)
//               out_instr/out_imm   registered instruction and immediate
//               out_fmt/out_illegal registered format class / illegal flag
//               illegal_cnt         saturating illegal-opcode counter
// Revision    : 1.0 - initial release
// ============================================================================
module id_imm_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  output logic [1:0]       imm_sel,
  output logic [31:0]      imm_in,
  input  logic [31:0]      imm_ext,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  // Opcodes (instr[6:0])
  localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] c_OP_IMM   = 7'b0010011;
  localparam logic [6:0] c_OP_JALR  = 7'b1100111;
  localparam logic [6:0] c_OP_STORE = 7'b0100011;
  localparam logic [6:0] c_OP_BR    = 7'b1100011;
  localparam logic [6:0] c_OP_JAL   = 7'b1101111;
  localparam logic [6:0] c_OP_REG   = 7'b0110011;
  localparam logic [6:0] c_OP_LUI   = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC = 7'b0010111;

  // Format classes reported on out_fmt
  localparam logic [2:0] c_FMT_NONE = 3'd0;
  localparam logic [2:0] c_FMT_I    = 3'd1;
  localparam logic [2:0] c_FMT_S    = 3'd2;
  localparam logic [2:0] c_FMT_B    = 3'd3;
  localparam logic [2:0] c_FMT_J    = 3'd4;
`ifdef IMM_UTYPE_EN
  localparam logic [2:0] c_FMT_U    = 3'd5;
`endif

  // Extender select encodings
  localparam logic [1:0] c_SEL_I = 2'b00;
  localparam logic [1:0] c_SEL_S = 2'b01;
  localparam logic [1:0] c_SEL_B = 2'b10;
  localparam logic [1:0] c_SEL_J = 2'b11;

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  logic [2:0]  w_fmt;
  logic [1:0]  w_sel;
  logic [31:0] w_imm;
  logic        w_illegal;
  logic        w_xfer_in;
  logic        w_xfer_out;

  // Opcode classification. Select defaults to I so the extender input is
  // always a defined format, even for classes that ignore its result.
  always_comb begin
    w_fmt     = c_FMT_NONE;
    w_sel     = c_SEL_I;
    w_imm     = 32'h0000_0000;
    w_illegal = 1'b0;
    case (in_instr[6:0])
      c_OP_LOAD, c_OP_IMM, c_OP_JALR: begin
        w_fmt = c_FMT_I;
        w_sel = c_SEL_I;
        w_imm = imm_ext;
      end
      c_OP_STORE: begin
        w_fmt = c_FMT_S;
        w_sel = c_SEL_S;
        w_imm = imm_ext;
      end
      c_OP_BR: begin
        w_fmt = c_FMT_B;
        w_sel = c_SEL_B;
        w_imm = imm_ext;
      end
      c_OP_JAL: begin
        w_fmt = c_FMT_J;
        w_sel = c_SEL_J;
        w_imm = imm_ext;
      end
      c_OP_REG: begin
        w_fmt = c_FMT_NONE;
      end
      c_OP_LUI, c_OP_AUIPC: begin
`ifdef IMM_UTYPE_EN
        // U immediate is a plain field placement; the extender is bypassed.
        w_fmt = c_FMT_U;
        w_imm = {in_instr[31:12], 12'h000};
`else
        w_illegal = 1'b1;
`endif
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  assign imm_sel    = w_sel;
  assign imm_in     = in_instr;
  assign in_ready   = !out_valid || out_ready;
  assign w_xfer_in  = in_valid && in_ready && !flush;
  assign w_xfer_out = out_valid && out_ready;

  // ID/EX slice. Flush only clears the valid bit; payload fields keep
  // stale contents and are qualified by out_valid downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_instr   <= 32'h0000_0000;
      out_imm     <= 32'h0000_0000;
      out_fmt     <= c_FMT_NONE;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (w_xfer_in) begin
      out_valid   <= 1'b1;
      out_instr   <= in_instr;
      out_imm     <= w_imm;
      out_fmt     <= w_fmt;
      out_illegal <= w_illegal;
    end else if (w_xfer_out) begin
      out_valid <= 1'b0;
    end
  end

  // Illegal-opcode counter: only accepted (non-flushed) instructions count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (w_xfer_in && w_illegal && (illegal_cnt != c_CNT_MAX)) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_imm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_imm_sequencer
// Description : Scoreboard bench for id_imm_sequencer. Stimulus pushes the
//               hand-computed expected entry for each accepted instruction;
//               a monitor pops and compares whenever the ID/EX slice is
//               consumed. Honours IMM_UTYPE_EN for LUI expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_imm_sequencer;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [31:0]      in_instr;
  logic             in_ready;
  logic [1:0]       imm_sel;
  logic [31:0]      imm_in;
  logic [31:0]      imm_ext;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [31:0]      out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_cnt;

  id_imm_sequencer #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .imm_sel     (imm_sel),
    .imm_in      (imm_in),
    .imm_ext     (imm_ext),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_imm     (out_imm),
    .out_fmt     (out_fmt),
    .out_illegal (out_illegal),
    .illegal_cnt (illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every consumed ID/EX entry against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: got instr %h expected none", out_instr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_instr",   out_instr,            e.instr);
        chk("mon_imm",     out_imm,              e.imm);
        chk("mon_fmt",     {29'd0, out_fmt},     {29'd0, e.fmt});
        chk("mon_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
      end
    end
  end

  // Present one instruction; checks the combinational extender drive, waits
  // (bounded) for acceptance, records the expected entry. Leaves in_valid high.
  task automatic issue(input logic [31:0] ins, input logic [31:0] ext,
                       input logic [1:0] sel, input logic [2:0] fmt,
                       input logic [31:0] imm, input logic ill);
    int n;
    exp_t e;
    in_valid = 1'b1;
    in_instr = ins;
    imm_ext  = ext;
    @(negedge clk);
    chk("imm_sel", {30'd0, imm_sel}, {30'd0, sel});
    chk("imm_in",  imm_in, ins);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
    end
    e.instr = ins; e.imm = imm; e.fmt = fmt; e.ill = ill;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  logic [7:0] exp_cnt;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    imm_ext   = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid",   {31'd0, out_valid},   32'd0);
    chk("rst_out_instr",   out_instr,            32'd0);
    chk("rst_out_imm",     out_imm,              32'd0);
    chk("rst_out_fmt",     {29'd0, out_fmt},     32'd0);
    chk("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
    chk("rst_illegal_cnt", {24'd0, illegal_cnt}, 32'd0);
    chk("rst_in_ready",    {31'd0, in_ready},    32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // addi: I-type, one-cycle latency
    out_ready = 1'b1;
    issue(32'hFFF00093, 32'hFFFFFFFF, 2'b00, 3'd1, 32'hFFFFFFFF, 1'b0);
    idle();
    chk("addi_latency_valid", {31'd0, out_valid}, 32'd1);
    chk("addi_imm_direct",    out_imm,            32'hFFFFFFFF);
    @(posedge clk); #1;

    // jal under a 3-cycle stall
    out_ready = 1'b0;
    issue(32'h004000EF, 32'h00000004, 2'b11, 3'd4, 32'h00000004, 1'b0);
    idle();
    in_instr = 32'h00000013;
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid",    {31'd0, out_valid}, 32'd1);
      chk("stall_fmt",      {29'd0, out_fmt},   32'd4);
      chk("stall_imm",      out_imm,            32'h00000004);
      chk("stall_in_ready", {31'd0, in_ready},  32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("unstall_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Back-to-back sw then bne at full throughput
    issue(32'h00F12023, 32'h00000000, 2'b01, 3'd2, 32'h00000000, 1'b0);
    chk("b2b_valid_1", {31'd0, out_valid}, 32'd1);
    issue(32'hFEF51AE3, 32'hFFFFFFF4, 2'b10, 3'd3, 32'hFFFFFFF4, 1'b0);
    idle();
    chk("b2b_valid_2", {31'd0, out_valid}, 32'd1);
    chk("b2b_fmt_2",   {29'd0, out_fmt},   32'd3);
    @(posedge clk); #1;

    // Flush while an R-type entry is held and an illegal word is incoming
    out_ready = 1'b0;
    issue(32'h002081B3, 32'hDEADBEEF, 2'b00, 3'd0, 32'h00000000, 1'b0);
    in_valid = 1'b1;
    in_instr = 32'h0000007F;
    flush    = 1'b1;
    @(negedge clk);
    chk("held_rtype_imm", out_imm,          32'h00000000);
    chk("held_rtype_fmt", {29'd0, out_fmt}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    idle();
    void'(sb.pop_front());  // held entry was squashed, never consumed
    chk("flush_valid", {31'd0, out_valid},   32'd0);
    chk("flush_cnt",   {24'd0, illegal_cnt}, 32'd0);

    // Flush together with out_ready: held entry consumed, nothing loaded
    out_ready = 1'b1;
    issue(32'h00500113, 32'h00000005, 2'b00, 3'd1, 32'h00000005, 1'b0);
    in_instr = 32'h0000007F;
    flush    = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    idle();
    chk("flush_consume_valid", {31'd0, out_valid},   32'd0);
    chk("flush_consume_cnt",   {24'd0, illegal_cnt}, 32'd0);

    // lui
`ifdef IMM_UTYPE_EN
    issue(32'h123450B7, 32'hAAAAAAAA, 2'b00, 3'd5, 32'h12345000, 1'b0);
    exp_cnt = 8'd0;
`else
    issue(32'h123450B7, 32'hAAAAAAAA, 2'b00, 3'd0, 32'h00000000, 1'b1);
    exp_cnt = 8'd1;
`endif
    idle();
    chk("lui_cnt", {24'd0, illegal_cnt}, {24'd0, exp_cnt});
    @(posedge clk); #1;

    // 300 illegal opcodes -> counter saturates
    for (int i = 0; i < 300; i++) begin
      issue(32'h0000007F, 32'h12341234, 2'b00, 3'd0, 32'h00000000, 1'b1);
    end
    idle();
    chk("sat_cnt", {24'd0, illegal_cnt}, 32'd255);
    @(posedge clk); #1;

    // Asynchronous reset during a stall clears entry and counter at once
    out_ready = 1'b0;
    issue(32'h00F12023, 32'h00000000, 2'b01, 3'd2, 32'h00000000, 1'b0);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_front());
    chk("async_rst_valid", {31'd0, out_valid},   32'd0);
    chk("async_rst_cnt",   {24'd0, illegal_cnt}, 32'd0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
